// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter: shares one multi-cycle memory between I-fill, D-fill and D-store
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       icache_miss,
    input  logic [15:0]                icache_addr,
    input  logic                       dcache_miss,
    input  logic [15:0]                dcache_addr,
    input  logic                       dcache_wr,
    input  logic [15:0]                dcache_wdata,
    input  logic [15:0]                mem_rdata,
    input  logic                       mem_data_valid,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_wdata,
    output logic [15:0]                fill_data,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic                       fill_wen_i,
    output logic                       fill_wen_d,
    output logic                       icache_done,
    output logic                       dcache_done,
    output logic                       stall_fetch,
    output logic                       stall_mem
);

    localparam int c_cnt_w = $clog2(WORDS);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WORDS - 1);

    if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_param_check
        $error("mem_arbiter: WORDS must be a power of two >= 2 and MEM_LAT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D_FILL  = 3'd1,
        D_WRITE = 3'd2,
        I_FILL  = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [c_cnt_w-1:0]   r_issue_cnt;
    logic [c_cnt_w-1:0]   r_recv_cnt;
    logic                 r_issue_all;
    logic [15:0]          r_base;
    logic                 w_fill_st;
    logic                 w_issuing;
    logic                 w_last;

    assign w_fill_st = (r_state == D_FILL) || (r_state == I_FILL);
    // r_issue_all marks the counter having reached WORDS without widening it
    assign w_issuing = w_fill_st && !r_issue_all;
    assign w_last    = w_fill_st && mem_data_valid && (r_recv_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_issue_all <= 1'b0;
            r_base      <= '0;
        end else begin
            r_state <= w_state_nx;
            // block base is latched every idle cycle, so it holds the value seen on entry
            if (r_state == IDLE)
                r_base <= (dcache_miss ? dcache_addr : icache_addr) & 16'hFFF0;
            if (w_last) begin
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
                r_issue_all <= 1'b0;
            end else begin
                if (w_issuing) begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                    if (r_issue_cnt == c_last)
                        r_issue_all <= 1'b1;
                end
                if (w_fill_st && mem_data_valid)
                    r_recv_cnt <= r_recv_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 16'h0000;
        mem_wdata   = 16'h0000;
        fill_word   = '0;
        fill_wen_i  = 1'b0;
        fill_wen_d  = 1'b0;
        icache_done = 1'b0;
        dcache_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (dcache_wr)
                    w_state_nx = D_WRITE;
                else if (dcache_miss)
                    w_state_nx = D_FILL;
                else if (icache_miss)
                    w_state_nx = I_FILL;
            end
            D_WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = dcache_addr;
                mem_wdata   = dcache_wdata;
                dcache_done = 1'b1;
                w_state_nx  = GAP;
            end
            D_FILL, I_FILL: begin
                mem_en = w_issuing;
                if (w_issuing)
                    mem_addr = r_base + {{(15 - c_cnt_w){1'b0}}, r_issue_cnt, 1'b0};
                if (mem_data_valid) begin
                    fill_word = r_recv_cnt;
                    if (r_state == D_FILL)
                        fill_wen_d = 1'b1;
                    else
                        fill_wen_i = 1'b1;
                end
                if (w_last) begin
                    if (r_state == D_FILL)
                        dcache_done = 1'b1;
                    else
                        icache_done = 1'b1;
                    w_state_nx = GAP;
                end
            end
            GAP:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    assign fill_data   = mem_rdata;
    assign stall_fetch = icache_miss & ~icache_done;
    assign stall_mem   = (dcache_miss | dcache_wr) & ~dcache_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter: vector table plus scoreboard bench for mem_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_addr = 16'h0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_addr = 16'h0;
    logic        dcache_wr = 1'b0;
    logic [15:0] dcache_wdata = 16'h0;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, fill_data;
    logic [2:0]  fill_word;
    logic        fill_wen_i, fill_wen_d, icache_done, dcache_done, stall_fetch, stall_mem;
    logic        extra_valid = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_addr(icache_addr),
        .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
        .dcache_wr(dcache_wr), .dcache_wdata(dcache_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_wen_i(fill_wen_i), .fill_wen_d(fill_wen_d),
        .icache_done(icache_done), .dcache_done(dcache_done),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // memory: a read issued in cycle k returns data in cycle k+MEM_LAT; never reset
    logic [MEM_LAT-1:0] pv = '0;
    logic [15:0]        pa [MEM_LAT];
    always @(posedge clk) begin
        pv    <= {pv[MEM_LAT-2:0], mem_en & ~mem_wr};
        pa[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
    end
    assign mem_data_valid = pv[MEM_LAT-1] | extra_valid;
    assign mem_rdata      = mem_data_valid ? mdata(pa[MEM_LAT-1]) : 16'h0000;

    typedef struct packed { logic side; logic [2:0] word; logic [15:0] data; } fill_t;
    fill_t       fill_q[$];
    logic [15:0] iss_q[$];
    logic [31:0] wr_q[$];

    int errors = 0, checks = 0;
    int cyc = 0, fill_seen = 0, en_seen = 0, idone = 0, ddone = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, expected none (cycle %0d)", name, act, cyc);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        fill_t       f;
        logic [31:0] w;
        chk("stall_fetch", stall_fetch, icache_miss & ~icache_done);
        chk("stall_mem", stall_mem, (dcache_miss | dcache_wr) & ~dcache_done);
        if (mem_en === 1'b1) begin
            en_seen++;
            if (mem_wr) begin
                if (wr_q.size() == 0) fail("unexpected write", mem_addr);
                else begin
                    w = wr_q.pop_front();
                    chk("write addr/data", {mem_addr, mem_wdata}, w);
                end
            end else begin
                if (iss_q.size() == 0) fail("unexpected read", mem_addr);
                else chk("read addr", mem_addr, iss_q.pop_front());
            end
        end
        if (fill_wen_i === 1'b1 || fill_wen_d === 1'b1) begin
            fill_seen++;
            chk("single fill side", fill_wen_i & fill_wen_d, 1'b0);
            if (fill_q.size() == 0) fail("unexpected fill", {fill_wen_d, fill_word});
            else begin
                f = fill_q.pop_front();
                chk("fill side", fill_wen_d, f.side);
                chk("fill word", fill_word, f.word);
                chk("fill data", fill_data, f.data);
            end
        end
        if (icache_done === 1'b1) idone++;
        if (dcache_done === 1'b1) ddone++;
    end

    typedef struct {
        int          kind;      // 0 I fill, 1 D fill, 2 D store
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_base;
        int          exp_lat;
        int          exp_issues;
        int          exp_fills;
        logic [1:0]  exp_done;  // {icache_done, dcache_done}
    } vec_t;

    vec_t vecs[6];

    task automatic push_fill(input logic side, input logic [15:0] base);
        for (int w = 0; w < WORDS; w++) begin
            iss_q.push_back(base + 16'(2 * w));
            fill_q.push_back(fill_t'{side, 3'(w), mdata(base + 16'(2 * w))});
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t0 = -1, t1 = -1;
        int f0 = fill_seen, e0 = en_seen;
        if (v.kind == 2) wr_q.push_back({v.addr, v.wdata});
        else push_fill(v.kind == 1, v.exp_base);
        @(negedge clk);
        case (v.kind)
            0:       begin icache_miss = 1'b1; icache_addr = v.addr; end
            1:       begin dcache_miss = 1'b1; dcache_addr = v.addr; end
            default: begin dcache_wr = 1'b1; dcache_addr = v.addr; dcache_wdata = v.wdata; end
        endcase
        for (int i = 0; i < 40 && t1 < 0; i++) begin
            @(negedge clk);
            if (mem_en === 1'b1 && t0 < 0) begin
                t0 = cyc;
                chk("first mem_addr", mem_addr, v.exp_base);
            end
            if (icache_done === 1'b1 || dcache_done === 1'b1) begin
                t1 = cyc;
                chk("done side", {icache_done, dcache_done}, v.exp_done);
                #1;
                icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr = 1'b0;
            end
        end
        if (t1 < 0) begin
            fail("done timeout", v.addr);
            icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr = 1'b0;
        end else chk("done latency", t1 - t0, v.exp_lat);
        @(negedge clk);
        chk("stalls after done", {stall_fetch, stall_mem}, 2'b00);
        repeat (6) @(negedge clk);
        chk("issue count", en_seen - e0, v.exp_issues);
        chk("fill count", fill_seen - f0, v.exp_fills);
    endtask

    task automatic seq_both();
        int td = -1, ti = -1, tdone = -1, f_before = -1, sf_bad = 0;
        int f0 = fill_seen;
        push_fill(1'b1, 16'h0040);
        push_fill(1'b0, 16'h2000);
        @(negedge clk);
        dcache_miss = 1'b1; dcache_addr = 16'h0040;
        icache_miss = 1'b1; icache_addr = 16'h2000;
        for (int i = 0; i < 80 && tdone < 0; i++) begin
            @(negedge clk);
            if (icache_done !== 1'b1 && stall_fetch !== 1'b1) sf_bad++;
            if (mem_en === 1'b1 && mem_addr == 16'h2000 && ti < 0) begin
                ti = cyc;
                f_before = fill_seen - f0;
            end
            if (dcache_done === 1'b1 && td < 0) begin td = cyc; #1 dcache_miss = 1'b0; end
            if (icache_done === 1'b1) begin tdone = cyc; #1 icache_miss = 1'b0; end
        end
        if (tdone < 0) begin
            fail("both: I done timeout", 32'(td));
            icache_miss = 1'b0; dcache_miss = 1'b0;
        end
        chk("both: D done to I issue", ti - td, 3);
        chk("both: D fills before I issue", f_before, 8);
        chk("both: stall_fetch held", sf_bad, 0);
        chk("both: I fill latency", tdone - ti, 11);
        repeat (4) @(negedge clk);
    endtask

    task automatic seq_reset();
        int n = 0, f1, d1;
        push_fill(1'b0, 16'h0300);
        @(negedge clk);
        icache_miss = 1'b1; icache_addr = 16'h0304;
        for (int i = 0; i < 30 && n < 3; i++) begin
            @(negedge clk);
            if (fill_wen_i === 1'b1) n++;
        end
        chk("reset: third word seen", n, 3);
        #1 rst = 1'b1; icache_miss = 1'b0;
        #1 chk("reset: outputs zero",
               {mem_en, mem_wr, fill_wen_i, fill_wen_d, icache_done, dcache_done,
                stall_fetch, stall_mem, mem_addr, mem_wdata}, 64'h0);
        iss_q.delete();
        fill_q.delete();
        f1 = fill_seen;
        d1 = idone + ddone;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("reset: late valids ignored", fill_seen - f1, 0);
        chk("reset: no done pulse", idone + ddone - d1, 0);
        run_vec(vecs[1]);
    endtask

    task automatic seq_hold(input bit keep);
        int t1 = -1, ts = -1, t2 = -1;
        int e0 = en_seen, i0 = idone;
        push_fill(1'b0, 16'h0500);
        if (keep) push_fill(1'b0, 16'h0500);
        @(negedge clk);
        icache_miss = 1'b1; icache_addr = 16'h050A;
        for (int i = 0; i < 30 && t1 < 0; i++) begin
            @(negedge clk);
            if (icache_done === 1'b1) t1 = cyc;
        end
        @(negedge clk);
        chk("hold: stall_fetch in gap", stall_fetch, 1'b1);
        @(negedge clk);
        if (!keep) begin
            #1 icache_miss = 1'b0;
            repeat (12) @(negedge clk);
            chk("hold: one fill issues", en_seen - e0, 8);
            chk("hold: one done", idone - i0, 1);
        end else begin
            for (int i = 0; i < 30 && t2 < 0; i++) begin
                @(negedge clk);
                if (mem_en === 1'b1 && ts < 0) ts = cyc;
                if (icache_done === 1'b1) begin t2 = cyc; #1 icache_miss = 1'b0; end
            end
            icache_miss = 1'b0;
            repeat (8) @(negedge clk);
            chk("rehold: second fill start", ts - t1, 3);
            chk("rehold: two fills issued", en_seen - e0, 16);
            chk("rehold: two dones", idone - i0, 2);
        end
    endtask

    initial begin
        int f0;
        vecs[0] = '{0, 16'h1234, 16'h0000, 16'h1230, 11, 8, 8, 2'b10};
        vecs[1] = '{1, 16'h0F0E, 16'h0000, 16'h0F00, 11, 8, 8, 2'b01};
        vecs[2] = '{2, 16'h00A6, 16'hBEEF, 16'h00A6,  0, 1, 0, 2'b01};
        vecs[3] = '{0, 16'hFFFF, 16'h0000, 16'hFFF0, 11, 8, 8, 2'b10};
        vecs[4] = '{1, 16'h8001, 16'h0000, 16'h8000, 11, 8, 8, 2'b01};
        vecs[5] = '{2, 16'h7FFE, 16'h1234, 16'h7FFE,  0, 1, 0, 2'b01};

        #1 rst = 1'b1;
        #1 chk("reset state",
               {mem_en, mem_wr, fill_wen_i, fill_wen_d, icache_done, dcache_done,
                stall_fetch, stall_mem, mem_addr, mem_wdata}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // stray valids while idle must not fill or advance the receive counter
        f0 = fill_seen;
        extra_valid = 1'b1;
        repeat (3) @(negedge clk);
        extra_valid = 1'b0;
        @(negedge clk);
        chk("idle valid ignored", fill_seen - f0, 0);
        run_vec(vecs[0]);

        seq_both();
        seq_reset();
        seq_hold(1'b0);
        seq_hold(1'b1);

        chk("scoreboard drained", iss_q.size() + fill_q.size() + wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared multi-cycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sequences 8-word block fills: issues consecutive word reads, counts returned data, and steers each word to the requesting cache's fill port.
- Produces the stall signals that deassert the pipeline-register write enables (if_id and the later stages) while a miss or store is outstanding.

Parameters:
- WORDS, 8, words per cache block; issue and receive counters are log2(WORDS) bits wide.
- MEM_LAT, 4, memory read latency in cycles, request to mem_data_valid; used only by the bench memory model.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_miss  in  1  I-cache miss request; level, held until icache_done.
- icache_addr  in  16  I-cache miss byte address.
- dcache_miss  in  1  D-cache miss request; level, held until dcache_done.
- dcache_addr  in  16  D-cache miss or store byte address.
- dcache_wr  in  1  D-cache write-through store request; level, held until dcache_done.
- dcache_wdata  in  16  store data.
- mem_rdata  in  16  memory read data.
- mem_data_valid  in  1  mem_rdata is valid this cycle.
- mem_en  out  1  memory request strobe.
- mem_wr  out  1  1 = write, 0 = read; meaningful only while mem_en = 1.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- fill_data  out  16  word being filled; equals mem_rdata.
- fill_word  out  3  word index within the block being filled.
- fill_wen_i  out  1  I-cache data-array write enable.
- fill_wen_d  out  1  D-cache data-array write enable.
- icache_done  out  1  one-cycle pulse: I-cache fill complete.
- dcache_done  out  1  one-cycle pulse: D-cache fill or store complete.
- stall_fetch  out  1  hold PC and if_id.
- stall_mem  out  1  hold all pipeline registers.

Behaviour:
- Reset:
  - state = IDLE; issue_cnt = recv_cnt = 0.
  - mem_en, mem_wr, all fill_wen, all done and both stalls = 0; mem_addr and mem_wdata = 0.
  - Reset mid-operation aborts the transaction with no done pulse.
  - A late mem_data_valid after reset is ignored, because it arrives in IDLE.
- States: IDLE, D_FILL, D_WRITE, I_FILL, GAP.
- IDLE priority, highest first:
  - dcache_wr -> D_WRITE;
  - else dcache_miss -> D_FILL;
  - else icache_miss -> I_FILL.
  - The D-side always wins over the I-side.
- FILL states (D_FILL, I_FILL):
  - base = addr & 0xFFF0, sampled on entry.
  - mem_en = 1 and mem_wr = 0 for WORDS consecutive cycles, starting the first cycle in the state.
  - mem_addr = base + 2*issue_cnt; issue_cnt increments after each issue and stops at WORDS.
  - On each mem_data_valid: the requesting side's fill_wen = 1, fill_word = recv_cnt, fill_data = mem_rdata; then recv_cnt increments.
  - When the valid with recv_cnt = WORDS-1 arrives: assert that side's done in the same cycle, clear both counters, go to GAP.
  - Fill latency with MEM_LAT = 4: 8 issue cycles, done in cycle 11 counting the first issue cycle as 0.
- D_WRITE:
  - One cycle with mem_en = 1, mem_wr = 1, mem_addr = dcache_addr, mem_wdata = dcache_wdata.
  - dcache_done pulses in that same cycle; then go to GAP.
- GAP:
  - One cycle with no grant, giving the cache time to drop its request line.
  - Always returns to IDLE.
- mem_data_valid outside the FILL states is ignored.
- Stalls (combinational):
  - stall_fetch = icache_miss & ~icache_done.
  - stall_mem = (dcache_miss | dcache_wr) & ~dcache_done.
  - Pipeline enable = ~(stall_fetch | stall_mem) for if_id; ~stall_mem for the id_ex, ex_mem and mem_wb registers.
- Simultaneous icache_miss and dcache_miss:
  - The D fill runs first, then GAP.
  - I_FILL starts at the next IDLE if icache_miss is still high.
  - stall_fetch stays high throughout.
- No starvation guarantee is provided; the D-side generates at most one request per instruction.

Test Plan:
- Reset, then icache_miss = 1 with icache_addr = 0x1234 -> mem_addr issues 0x1230, 0x1232, … 0x123E on 8 consecutive cycles; fill_word 0..7 follows each mem_data_valid; icache_done pulses once, 11 cycles after the first issue; stall_fetch = 0 the next cycle.
- dcache_miss and icache_miss raised in the same cycle, addresses 0x0040 and 0x2000 -> all fill_wen_d pulses complete before the first mem_addr = 0x2000; exactly one GAP cycle separates the two fills; stall_mem = 1 only until dcache_done.
- dcache_wr = 1, addr 0x00A6, wdata 0xBEEF -> exactly one cycle of mem_en = 1, mem_wr = 1, addr 0x00A6, data 0xBEEF; dcache_done in that cycle; no fill_wen pulses.
- Assert rst after the 3rd returned word of an I fill -> all outputs go to 0 immediately; no done pulse; the remaining mem_data_valid pulses produce no fill_wen; a new dcache_miss is then served normally.
- icache_miss held high 2 cycles past icache_done -> exactly one fill per request; a second fill starts only if the miss is still high when the state returns to IDLE after GAP.
- mem_data_valid pulsed while in IDLE -> no fill_wen pulses and no change to either counter.
